// File: rtl/imem_dmem_arbiter_pkg.sv
// rtl/imem_dmem_arbiter_pkg.sv - state encoding, owner ids and default line size shared by the arbiter
package imem_dmem_arbiter_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_BURST_I = 2'd1;
   localparam logic [1:0] ST_BURST_D = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      BURST_I = ST_BURST_I,
      BURST_D = ST_BURST_D,
      DONE    = ST_DONE
   } arb_state_t;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   localparam int DEFAULT_BURST_LEN = 4;

endpackage

// File: rtl/imem_dmem_arbiter_burst_addr_gen.sv
// rtl/imem_dmem_arbiter_burst_addr_gen.sv - line base/offset latch, issued-beat counter, wrapping beat address
module imem_dmem_arbiter_burst_addr_gen
   import imem_dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 30,
   parameter int BURST_LEN  = DEFAULT_BURST_LEN,
   parameter int OFF_W      = $clog2(BURST_LEN)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  issue_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  all_issued_o
);

   localparam int               CNT_W   = OFF_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

   logic [ADDR_WIDTH-OFF_W-1:0] base_q, base_d;
   logic [OFF_W-1:0]            off_q, off_d, off_inc;
   logic [CNT_W-1:0]            issued_q, issued_d;

   // Offset only ever counts within OFF_W bits, so the wrap never reaches the line base.
   imem_dmem_arbiter_incr #(.W(OFF_W)) u_off_incr (
      .val_i (off_q),
      .val_o (off_inc)
   );

   always_comb begin
      base_d   = base_q;
      off_d    = off_q;
      issued_d = issued_q;
      if (load_i) begin
         base_d   = addr_i[ADDR_WIDTH-1:OFF_W];
         off_d    = addr_i[OFF_W-1:0];
         issued_d = '0;
      end else if (issue_i && (issued_q != CNT_MAX)) begin
         off_d    = off_inc;
         issued_d = issued_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         base_q   <= '0;
         off_q    <= '0;
         issued_q <= '0;
      end else begin
         base_q   <= base_d;
         off_q    <= off_d;
         issued_q <= issued_d;
      end
   end

   assign addr_o       = {base_q, off_q};
   assign all_issued_o = (issued_q == CNT_MAX);

endmodule

// File: rtl/imem_dmem_arbiter_incr.sv
// rtl/imem_dmem_arbiter_incr.sv - modulo-2^W incrementer
module imem_dmem_arbiter_incr #(
   parameter int W = 2
) (
   input  logic [W-1:0] val_i,
   output logic [W-1:0] val_o
);

   assign val_o = val_i + W'(1);

endmodule

// File: rtl/imem_dmem_arbiter.sv
// rtl/imem_dmem_arbiter.sv - round-robin I/D line-burst arbiter onto one memory port
module imem_dmem_arbiter
   import imem_dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 30,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = DEFAULT_BURST_LEN,
   parameter int OFF_W      = $clog2(BURST_LEN)
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  i_req_i,
   input  logic [ADDR_WIDTH-1:0] i_addr_i,
   output logic                  i_rvalid_o,
   output logic [DATA_WIDTH-1:0] i_rdata_o,
   output logic                  i_done_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   output logic                  d_wready_o,
   output logic                  d_rvalid_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   output logic                  d_done_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int               CNT_W   = OFF_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN);

   arb_state_t          state_q, state_d;
   logic                last_owner_q, last_owner_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [CNT_W-1:0]    rcvd_q, rcvd_d;
   logic                load;
   logic [ADDR_WIDTH-1:0] load_addr;
   logic                all_issued;
   logic                in_burst;
   logic                beat_issue;
   logic                rsp;

   imem_dmem_arbiter_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BURST_LEN  (BURST_LEN),
      .OFF_W      (OFF_W)
   ) u_addr_gen (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .load_i       (load),
      .addr_i       (load_addr),
      .issue_i      (beat_issue),
      .addr_o       (mem_addr_o),
      .all_issued_o (all_issued)
   );

   assign in_burst   = (state_q == BURST_I) || (state_q == BURST_D);
   assign mem_req_o  = in_burst && !all_issued;
   assign mem_we_o   = (state_q == BURST_D) && we_q;
   assign beat_issue = mem_req_o && mem_gnt_i;
   // Responses outside a burst are protocol errors and are dropped here.
   assign rsp        = in_burst && mem_rvalid_i;

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      owner_d      = owner_q;
      we_d         = we_q;
      rcvd_d       = rcvd_q;
      load         = 1'b0;
      load_addr    = i_addr_i;
      case (state_q)
         IDLE: begin
            rcvd_d = '0;
            if (i_req_i && (!d_req_i || (last_owner_q == OWNER_D))) begin
               load         = 1'b1;
               load_addr    = i_addr_i;
               owner_d      = OWNER_I;
               last_owner_d = OWNER_I;
               we_d         = 1'b0;
               state_d      = BURST_I;
            end else if (d_req_i) begin
               load         = 1'b1;
               load_addr    = d_addr_i;
               owner_d      = OWNER_D;
               last_owner_d = OWNER_D;
               we_d         = d_we_i;
               state_d      = BURST_D;
            end
         end
         BURST_I, BURST_D: begin
            if (rsp && (rcvd_q != CNT_MAX)) begin
               rcvd_d = rcvd_q + CNT_W'(1);
            end
            if (rcvd_d == CNT_MAX) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         last_owner_q <= OWNER_D;
         owner_q      <= OWNER_I;
         we_q         <= 1'b0;
         rcvd_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         rcvd_q       <= rcvd_d;
      end
   end

   // Data paths are gated by ownership so idle or reset states show all-zero outputs.
   assign i_rvalid_o  = rsp && (owner_q == OWNER_I);
   assign i_rdata_o   = (state_q == BURST_I) ? mem_rdata_i : '0;
   assign d_rvalid_o  = rsp && (owner_q == OWNER_D) && !we_q;
   assign d_rdata_o   = ((state_q == BURST_D) && !we_q) ? mem_rdata_i : '0;
   assign d_wready_o  = beat_issue && mem_we_o;
   assign mem_wdata_o = mem_we_o ? d_wdata_i : '0;
   assign i_done_o    = (state_q == DONE) && (owner_q == OWNER_I);
   assign d_done_o    = (state_q == DONE) && (owner_q == OWNER_D);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb/tb_imem_dmem_arbiter.sv - directed self-checking bench for imem_dmem_arbiter
module tb_imem_dmem_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        i_req_i;
   logic [29:0] i_addr_i;
   logic        i_rvalid_o;
   logic [31:0] i_rdata_o;
   logic        i_done_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [29:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic        d_wready_o;
   logic        d_rvalid_o;
   logic [31:0] d_rdata_o;
   logic        d_done_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [29:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int n_vec = 0;
   int n_err = 0;
   int n_wr;

   always #5 clk_i = ~clk_i;

   imem_dmem_arbiter dut (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .i_req_i      (i_req_i),
      .i_addr_i     (i_addr_i),
      .i_rvalid_o   (i_rvalid_o),
      .i_rdata_o    (i_rdata_o),
      .i_done_o     (i_done_o),
      .d_req_i      (d_req_i),
      .d_we_i       (d_we_i),
      .d_addr_i     (d_addr_i),
      .d_wdata_i    (d_wdata_i),
      .d_wready_o   (d_wready_o),
      .d_rvalid_o   (d_rvalid_o),
      .d_rdata_o    (d_rdata_o),
      .d_done_o     (d_done_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   // Entered with the FSM in IDLE and the request already raised; gnt tied high,
   // each read beat answered one cycle after its grant.
   task automatic burst_rd(input bit side_d, input logic [29:0] e0, input logic [29:0] e1,
                           input logic [29:0] e2, input logic [29:0] e3,
                           input logic [31:0] dbase, input bit drop);
      logic [29:0] ea [4];
      ea[0] = e0; ea[1] = e1; ea[2] = e2; ea[3] = e3;
      tick();
      mem_rvalid_i = 1'b0;
      #1;
      chk("rd_req", mem_req_o, 1);
      chk("rd_addr0", mem_addr_o, ea[0]);
      chk("rd_we", mem_we_o, 0);
      for (int k = 1; k < 5; k++) begin
         tick();
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = dbase + 32'(k - 1);
         #1;
         if (k < 4) chk("rd_addr", mem_addr_o, ea[k]);
         else       chk("rd_req_drop", mem_req_o, 0);
         chk("rd_rvalid", side_d ? d_rvalid_o : i_rvalid_o, 1);
         chk("rd_rdata", side_d ? d_rdata_o : i_rdata_o, dbase + 32'(k - 1));
         chk("rd_other_rvalid", side_d ? i_rvalid_o : d_rvalid_o, 0);
         chk("rd_no_early_done", {i_done_o, d_done_o}, 0);
      end
      tick();
      mem_rvalid_i = 1'b0;
      if (drop) begin
         if (side_d) d_req_i = 1'b0;
         else        i_req_i = 1'b0;
      end
      #1;
      chk("rd_done", side_d ? d_done_o : i_done_o, 1);
      chk("rd_other_done", side_d ? i_done_o : d_done_o, 0);
      chk("rd_done_noreq", mem_req_o, 0);
      tick();
      #1;
      chk("rd_done_pulse", {i_done_o, d_done_o}, 0);
   endtask

   initial begin
      rst_n_i = 1'b0;
      i_req_i = 1'b0; i_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      tick();
      tick();
      #1;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_done", {i_done_o, d_done_o}, 0);
      chk("rst_rvalid", {i_rvalid_o, d_rvalid_o}, 0);
      chk("rst_wready", d_wready_o, 0);
      rst_n_i = 1'b1;
      tick();

      // Both sides request right after reset: I, D, I, D.
      mem_gnt_i = 1'b1;
      i_addr_i = 30'h100; d_addr_i = 30'h208; d_we_i = 1'b0;
      i_req_i = 1'b1; d_req_i = 1'b1;
      burst_rd(1'b0, 30'h100, 30'h101, 30'h102, 30'h103, 32'h1100, 1'b0);
      burst_rd(1'b1, 30'h208, 30'h209, 30'h20A, 30'h20B, 32'h2200, 1'b0);
      burst_rd(1'b0, 30'h100, 30'h101, 30'h102, 30'h103, 32'h3300, 1'b1);
      burst_rd(1'b1, 30'h208, 30'h209, 30'h20A, 30'h20B, 32'h4400, 1'b1);

      // Single I refill, critical word first with wrap.
      i_addr_i = 30'h6; i_req_i = 1'b1;
      burst_rd(1'b0, 30'h6, 30'h7, 30'h4, 30'h5, 32'hA0, 1'b1);

      // D write-back, grant every other cycle, ack one cycle after each grant.
      d_we_i = 1'b1; d_addr_i = 30'h10; d_req_i = 1'b1; mem_gnt_i = 1'b0;
      n_wr = 0;
      tick();
      for (int c = 1; c <= 9; c++) begin
         if (c > 1) tick();
         mem_gnt_i    = (c % 2 == 0) && (c <= 8);
         mem_rvalid_i = (c % 2 == 1) && (c >= 3);
         d_wdata_i    = 32'hC0DE0000 + 32'(c);
         #1;
         if (c <= 8) begin
            chk("wb_req", mem_req_o, 1);
            chk("wb_addr", mem_addr_o, 30'h10 + 30'((c - 1) / 2));
            chk("wb_we", mem_we_o, 1);
         end else begin
            chk("wb_req_drop", mem_req_o, 0);
         end
         chk("wb_wready", d_wready_o, mem_gnt_i);
         if (mem_gnt_i) chk("wb_wdata", mem_wdata_o, 32'hC0DE0000 + 32'(c));
         chk("wb_no_rvalid", {i_rvalid_o, d_rvalid_o}, 0);
         chk("wb_no_early_done", d_done_o, 0);
         if (d_wready_o) n_wr++;
      end
      tick();
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
      #1;
      chk("wb_done", d_done_o, 1);
      chk("wb_wready_count", n_wr, 4);
      tick();
      #1;
      chk("wb_done_pulse", d_done_o, 0);

      // All grants first, then responses three cycles apart.
      i_addr_i = 30'h23; i_req_i = 1'b1;
      tick();
      for (int c = 1; c <= 4; c++) begin
         if (c > 1) tick();
         #1;
         chk("bp_req", mem_req_o, 1);
         chk("bp_addr", mem_addr_o, (c == 1) ? 30'h23 : 30'h20 + 30'(c - 2));
         chk("bp_no_rvalid", i_rvalid_o, 0);
      end
      for (int c = 5; c <= 14; c++) begin
         tick();
         mem_rvalid_i = ((c - 5) % 3 == 0);
         mem_rdata_i  = 32'hB0 + 32'(c);
         #1;
         chk("bp_req_low", mem_req_o, 0);
         chk("bp_rvalid", i_rvalid_o, mem_rvalid_i);
         if (mem_rvalid_i) chk("bp_rdata", i_rdata_o, 32'hB0 + 32'(c));
         chk("bp_hold_burst", i_done_o, 0);
      end
      tick();
      mem_rvalid_i = 1'b0; i_req_i = 1'b0;
      #1;
      chk("bp_done", i_done_o, 1);
      tick();
      #1;
      chk("bp_done_pulse", i_done_o, 0);

      // Asynchronous reset in the middle of a D refill.
      d_we_i = 1'b0; d_addr_i = 30'h31; d_req_i = 1'b1;
      tick();
      #1;
      chk("ar_addr0", mem_addr_o, 30'h31);
      tick();
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD0001;
      #1;
      chk("ar_addr1", mem_addr_o, 30'h32);
      chk("ar_rvalid", d_rvalid_o, 1);
      rst_n_i = 1'b0;
      #1;
      chk("ar_mem_req", mem_req_o, 0);
      chk("ar_mem_addr", mem_addr_o, 0);
      chk("ar_mem_we", mem_we_o, 0);
      chk("ar_mem_wdata", mem_wdata_o, 0);
      chk("ar_rvalid0", {i_rvalid_o, d_rvalid_o}, 0);
      chk("ar_rdata0", {i_rdata_o, d_rdata_o}, 0);
      chk("ar_done0", {i_done_o, d_done_o}, 0);
      chk("ar_wready0", d_wready_o, 0);
      d_req_i = 1'b0; mem_rvalid_i = 1'b0;
      tick();
      tick();
      rst_n_i = 1'b1;
      i_addr_i = 30'h45; i_req_i = 1'b1;
      burst_rd(1'b0, 30'h45, 30'h46, 30'h47, 30'h44, 32'h5000, 1'b1);

      // Stray response while idle.
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
      #1;
      chk("stray_rvalid", {i_rvalid_o, d_rvalid_o}, 0);
      chk("stray_rdata", {i_rdata_o, d_rdata_o}, 0);
      tick();
      #1;
      chk("stray_done", {i_done_o, d_done_o}, 0);
      chk("stray_req", mem_req_o, 0);
      mem_rvalid_i = 1'b0;
      d_we_i = 1'b0; d_addr_i = 30'h50; d_req_i = 1'b1;
      burst_rd(1'b1, 30'h50, 30'h51, 30'h52, 30'h53, 32'h6000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
